// File: rtl/pipe_pkg.sv
// pipe_pkg: opcodes, bubble constants and instruction tuple shared by the issue controller
package pipe_pkg;

    localparam int WB_LAT = 2;
    localparam int DEPTH  = 4;

    localparam logic [3:0] FUNC_ADD   = 4'd0;
    localparam logic [3:0] FUNC_SUB   = 4'd1;
    localparam logic [3:0] FUNC_OR    = 4'd2;
    localparam logic [3:0] FUNC_PASSA = 4'd3;
    localparam logic [3:0] FUNC_AND   = 4'd4;
    localparam logic [3:0] FUNC_XOR   = 4'd5;
    localparam logic [3:0] FUNC_PASSB = 4'd6;
    localparam logic [3:0] FUNC_NOTA  = 4'd7;
    localparam logic [3:0] FUNC_SLT   = 4'd8;
    localparam logic [3:0] FUNC_SHL   = 4'd9;
    localparam logic [3:0] FUNC_SHR   = 4'd10;
    localparam logic [3:0] FUNC_SHRB  = 4'd11;

    localparam logic [3:0] NOP_FUNC = FUNC_PASSA;
    localparam logic [7:0] SCR_ADDR = 8'd255;
    localparam logic [3:0] MAX_FUNC = FUNC_SHRB;

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } instr_t;

endpackage

// File: rtl/issue_fifo.sv
// issue_fifo: DEPTH-entry instruction FIFO with count-based full/empty
module issue_fifo
    import pipe_pkg::*;
#(
    parameter int DEPTH = pipe_pkg::DEPTH
) (
    input  logic   clk1,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  instr_t din,
    output instr_t head,
    output logic   full,
    output logic   empty
);
    localparam int AW = $clog2(DEPTH);

    instr_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // pointers wrap naturally because DEPTH is a power of two; push+pop leaves count unchanged
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // storage needs no reset: an entry is only read after it has been written
    always_ff @(posedge clk1) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// pipe_issue_ctrl: buffers instructions and issues one per cycle, stalling on RAW hazards
module pipe_issue_ctrl
    import pipe_pkg::*;
(
    input  logic        clk1,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_rs1,
    input  logic [3:0]  in_rs2,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_func,
    input  logic [7:0]  in_addr,
    input  logic        halt,
    output logic        iss_valid,
    output logic [3:0]  iss_rs1,
    output logic [3:0]  iss_rs2,
    output logic [3:0]  iss_rd,
    output logic [3:0]  iss_func,
    output logic [7:0]  iss_addr,
    output logic        busy,
    output logic        err_illegal,
    output logic [15:0] iss_cnt,
    output logic [15:0] stall_cnt
);
    instr_t            din;
    instr_t            head;
    logic              full;
    logic              empty;
    logic              push;
    logic              legal;
    logic              hazard;
    logic              issue;
    logic              drop;
    logic [WB_LAT-1:0] trk_v;
    logic [3:0]        trk_rd [WB_LAT];

    assign din      = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign legal    = head.func <= MAX_FUNC;
    assign issue    = !empty && !halt && !hazard && legal;
    assign drop     = !empty && !legal;
    assign busy     = !empty || (|trk_v);

    issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk1  (clk1),
        .rst   (rst),
        .push  (push),
        .pop   (issue || drop),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // the oldest tracker slot has already reached the regbank, so only younger slots block a fetch
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WB_LAT - 1; i++)
            hazard = hazard || (trk_v[i] && (trk_rd[i] == head.rs1 || trk_rd[i] == head.rs2));
    end

    // registered issue tuple, in-flight tracker, counters and sticky illegal flag
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            iss_valid   <= 1'b0;
            iss_rs1     <= '0;
            iss_rs2     <= '0;
            iss_rd      <= '0;
            iss_func    <= NOP_FUNC;
            iss_addr    <= SCR_ADDR;
            trk_v       <= '0;
            for (int i = 0; i < WB_LAT; i++) trk_rd[i] <= '0;
            iss_cnt     <= '0;
            stall_cnt   <= '0;
            err_illegal <= 1'b0;
        end else begin
            iss_valid   <= issue;
            iss_rs1     <= issue ? head.rs1 : '0;
            iss_rs2     <= issue ? head.rs2 : '0;
            iss_rd      <= issue ? head.rd : '0;
            iss_func    <= issue ? head.func : NOP_FUNC;
            iss_addr    <= issue ? head.addr : SCR_ADDR;
            trk_v[0]    <= issue;
            trk_rd[0]   <= issue ? head.rd : '0;
            for (int i = 1; i < WB_LAT; i++) begin
                trk_v[i]  <= trk_v[i-1];
                trk_rd[i] <= trk_rd[i-1];
            end
            iss_cnt     <= iss_cnt + 16'(issue);
            stall_cnt   <= stall_cnt + 16'(!empty && legal && !issue);
            err_illegal <= err_illegal || (push && in_func > MAX_FUNC);
        end
    end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// tb_pipe_issue_ctrl: directed and random stimulus checked against a cycle-indexed reference model
module tb_pipe_issue_ctrl;

    localparam int WB = 2;

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } ins_t;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0, in_func = '0;
    logic [7:0]  in_addr = '0;
    logic        halt = 1'b0;
    logic        iss_valid;
    logic [3:0]  iss_rs1, iss_rs2, iss_rd, iss_func;
    logic [7:0]  iss_addr;
    logic        busy, err_illegal;
    logic [15:0] iss_cnt, stall_cnt;

    pipe_issue_ctrl dut (
        .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func), .in_addr(in_addr),
        .halt(halt), .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_func(iss_func), .iss_addr(iss_addr), .busy(busy), .err_illegal(err_illegal),
        .iss_cnt(iss_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk1 = ~clk1;

    int checks = 0;
    int errors = 0;

    // reference model: a queue of pending instructions and, per register, the first edge
    // at which its pending write is visible to a fetch
    ins_t        q[$];
    int          ready_at[16];
    int          edge_n;
    int          last_iss;
    logic        m_v;
    ins_t        m_out;
    logic        m_err;
    logic [15:0] m_icnt, m_scnt;
    logic        m_push;

    localparam ins_t BUBBLE = '{rs1: 4'd0, rs2: 4'd0, rd: 4'd0, func: 4'd3, addr: 8'd255};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @%0t observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int r = 0; r < 16; r++) ready_at[r] = 0;
        edge_n   = 0;
        last_iss = -100;
        m_v      = 1'b0;
        m_out    = BUBBLE;
        m_err    = 1'b0;
        m_icnt   = '0;
        m_scnt   = '0;
    endtask

    task automatic model_step(input logic v, input ins_t x, input logic h);
        int   k;
        ins_t hd;
        k      = edge_n + 1;
        m_push = v && (q.size() != 4);
        m_v    = 1'b0;
        m_out  = BUBBLE;
        if (q.size() > 0) begin
            hd = q[0];
            if (hd.func > 4'd11) begin
                void'(q.pop_front());
            end else if (!h && k >= ready_at[hd.rs1] && k >= ready_at[hd.rs2]) begin
                void'(q.pop_front());
                m_v = 1'b1;
                m_out = hd;
                ready_at[hd.rd] = k + WB;
                last_iss = k;
                m_icnt++;
            end else begin
                m_scnt++;
            end
        end
        if (m_push) begin
            q.push_back(x);
            if (x.func > 4'd11) m_err = 1'b1;
        end
        edge_n = k;
    endtask

    task automatic check_all();
        chk("iss_valid", 32'(iss_valid), 32'(m_v));
        chk("iss_tuple", 32'({iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}), 32'(m_out));
        chk("in_ready", 32'(in_ready), 32'(q.size() != 4));
        chk("busy", 32'(busy), 32'(q.size() > 0 || (edge_n - last_iss) < WB));
        chk("err_illegal", 32'(err_illegal), 32'(m_err));
        chk("iss_cnt", 32'(iss_cnt), 32'(m_icnt));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    endtask

    task automatic cycle(input logic v, input ins_t x, input logic h);
        in_valid = v;
        {in_rs1, in_rs2, in_rd, in_func, in_addr} = x;
        halt = h;
        model_step(v, x, h);
        @(posedge clk1);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, BUBBLE, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(iss_valid), 32'd0);
        chk({tag, "_tuple"}, 32'({iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}), 32'(BUBBLE));
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_cnts"}, 32'({iss_cnt, stall_cnt}), 32'd0);
        chk({tag, "_err"}, 32'(err_illegal), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        in_valid = 1'b0;
        halt = 1'b0;
        #1 rst = 1'b1;
        #1 check_reset_state(tag);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        ins_t x;
        model_reset();
        repeat (2) @(posedge clk1);
        #1 check_reset_state("por");
        rst = 1'b0;

        // independent pair issues on consecutive cycles
        cycle(1'b1, '{rs1: 3, rs2: 5, rd: 10, func: 0, addr: 125}, 1'b0);
        cycle(1'b1, '{rs1: 1, rs2: 5, rd: 12, func: 2, addr: 127}, 1'b0);
        chk("t1_first_issued", 32'(iss_valid), 32'd1);
        cycle(1'b0, BUBBLE, 1'b0);
        chk("t1_second_issued", 32'(iss_valid), 32'd1);
        idle(3);
        chk("t1_stall", 32'(stall_cnt), 32'd0);

        // RAW pair separated by exactly one bubble
        do_reset("r2");
        cycle(1'b1, '{rs1: 3, rs2: 5, rd: 10, func: 0, addr: 125}, 1'b0);
        cycle(1'b1, '{rs1: 10, rs2: 5, rd: 11, func: 1, addr: 126}, 1'b0);
        cycle(1'b0, BUBBLE, 1'b0);
        chk("t2_bubble", 32'(iss_valid), 32'd0);
        cycle(1'b0, BUBBLE, 1'b0);
        chk("t2_consumer", 32'({iss_valid, iss_addr}), 32'({1'b1, 8'd126}));
        idle(3);
        chk("t2_stall", 32'(stall_cnt), 32'd1);

        // backpressure under halt, then drain in order
        do_reset("r3");
        for (int i = 0; i < 5; i++) begin
            x = '{rs1: 1, rs2: 2, rd: 4'(4 + i), func: 0, addr: 8'(i)};
            cycle(1'b1, x, 1'b1);
            if (i == 4) begin
                chk("t3_fifth_held", 32'(m_push), 32'd0);
                for (int t = 0; t < 8 && !m_push; t++) cycle(1'b1, x, 1'b0);
            end
            if (i == 3) chk("t3_ready_low", 32'(in_ready), 32'd0);
        end
        idle(8);
        chk("t3_iss_cnt", 32'(iss_cnt), 32'd5);

        // illegal op between two legal ops
        do_reset("r4");
        cycle(1'b1, '{rs1: 1, rs2: 2, rd: 3, func: 0, addr: 10}, 1'b0);
        cycle(1'b1, '{rs1: 1, rs2: 2, rd: 4, func: 13, addr: 11}, 1'b0);
        cycle(1'b1, '{rs1: 1, rs2: 2, rd: 5, func: 0, addr: 12}, 1'b0);
        idle(5);
        chk("t4_err", 32'(err_illegal), 32'd1);
        chk("t4_iss_cnt", 32'(iss_cnt), 32'd2);

        // asynchronous reset with work queued and in flight
        do_reset("r5");
        for (int i = 0; i < 4; i++) cycle(1'b1, '{rs1: 1, rs2: 2, rd: 4'(6 + i), func: 0, addr: 8'(20 + i)}, 1'b1);
        cycle(1'b1, '{rs1: 1, rs2: 2, rd: 4'd15, func: 0, addr: 8'd30}, 1'b0);
        cycle(1'b1, '{rs1: 1, rs2: 2, rd: 4'd15, func: 0, addr: 8'd30}, 1'b0);
        chk("t5_busy_before", 32'(busy), 32'd1);
        do_reset("t5_mid");
        cycle(1'b1, '{rs1: 7, rs2: 8, rd: 9, func: 4, addr: 40}, 1'b0);
        cycle(1'b0, BUBBLE, 1'b0);
        chk("t5_fresh_issue", 32'({iss_valid, iss_addr}), 32'({1'b1, 8'd40}));

        // issue counter wraps
        do_reset("r6");
        force dut.iss_cnt = 16'hffff;
        #1 release dut.iss_cnt;
        m_icnt = 16'hffff;
        cycle(1'b1, '{rs1: 1, rs2: 1, rd: 2, func: 0, addr: 50}, 1'b0);
        cycle(1'b0, BUBBLE, 1'b0);
        chk("t6_wrap", 32'(iss_cnt), 32'd0);

        // random traffic with hazards, halts and illegal ops
        do_reset("r7");
        for (int n = 0; n < 600; n++) begin
            x = '{rs1: 4'($urandom_range(0, 7)), rs2: 4'($urandom_range(0, 7)),
                  rd: 4'($urandom_range(0, 7)), func: 4'($urandom_range(0, 13)),
                  addr: 8'($urandom_range(0, 255))};
            cycle(($urandom % 4) != 0, x, ($urandom % 6) == 0);
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
